// File: rtl/mgc_out_fifo_wait_grn.sv
// mgc_out_fifo_wait_grn
//
// Buffered output channel between the green-tint datapath core and the pixel
// sink. Words written by the core (ld/vd handshake) are held in a circular
// register array and presented in order to the consumer (lz/vz handshake).
//
// Parameters:
//   rscid   - resource ID, informational only
//   width   - data word width in bits
//   fifo_sz - depth in words, 1..256, any integer
//   ph_log2 - ceil(log2(fifo_sz)); sizes the pointers, sz is ph_log2+1 bits
//
// Ports:
//   clk  in   clock, rising edge
//   srst in   synchronous reset, active-high, wins over en
//   en   in   clock enable; when low nothing moves
//   ld   in   core write request
//   vd   out  FIFO can accept a write (not full)
//   d    in   core write data
//   lz   out  head word valid (not empty)
//   vz   in   consumer ready
//   z    out  head word, zero while empty
//   sz   out  current occupancy 0..fifo_sz
//
// Build option:
//   MGC_OUT_FIFO_BYPASS_EN - when defined and the FIFO is empty, ld/d are
//   forwarded combinationally to lz/z and a word taken in the same cycle is
//   never stored. When undefined, all outputs are register-derived.

module mgc_out_fifo_wait_grn #(
  parameter int rscid   = 0,
  parameter int width   = 8,
  parameter int fifo_sz = 8,
  parameter int ph_log2 = 3
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               en,
  input  logic               ld,
  output logic               vd,
  input  logic [width-1:0]   d,
  output logic               lz,
  input  logic               vz,
  output logic [width-1:0]   z,
  output logic [ph_log2:0]   sz
);

  // A depth-1 FIFO has ph_log2 = 0; keep a 1-bit pointer that simply stays 0.
  localparam int PtrW = (ph_log2 > 0) ? ph_log2 : 1;
  localparam int CntW = ph_log2 + 1;

  localparam logic [PtrW-1:0] PtrLast = PtrW'(fifo_sz - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(fifo_sz);

  logic [width-1:0] mem [fifo_sz];

  logic [PtrW-1:0] wp_q, wp_d;
  logic [PtrW-1:0] rp_q, rp_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic empty;
  logic full;
  logic byp_take;
  logic wr_fire;
  logic rd_fire;

  // The resource ID has no functional effect.
  logic [31:0] unused_rscid;
  assign unused_rscid = rscid;

  // Circular advance that also handles non-power-of-two depths.
  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntFull);

  // Ready comes from the registered count only, so a full FIFO refuses a
  // write even when a read frees a slot in the same cycle.
  assign vd = ~full;
  assign sz = cnt_q;

`ifdef MGC_OUT_FIFO_BYPASS_EN
  // Empty and the consumer takes the word right away: it never enters storage.
  assign byp_take = empty & en & ld & vz;
  assign lz       = ~empty | ld;

  always_comb begin
    z = '0;
    if (!empty) begin
      z = mem[rp_q];
    end else if (ld) begin
      z = d;
    end
  end
`else
  assign byp_take = 1'b0;
  assign lz       = ~empty;

  always_comb begin
    z = '0;
    if (!empty) begin
      z = mem[rp_q];
    end
  end
`endif

  assign wr_fire = en & ld & ~full & ~byp_take;
  assign rd_fire = en & vz & ~empty;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (wr_fire) begin
      wp_d = ptr_next(wp_q);
    end
    if (rd_fire) begin
      rp_d = ptr_next(rp_q);
    end
    case ({wr_fire, rd_fire})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not cleared on reset; a write in the reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (!srst && wr_fire) begin
      mem[wp_q] <= d;
    end
  end

endmodule

// File: tb/tb_mgc_out_fifo_wait_grn.sv
module tb_mgc_out_fifo_wait_grn;

  logic       clk;
  logic       srst;
  logic       en;
  logic       ld;
  logic       vz;
  logic [7:0] d;

  logic       vd0, lz0, vd1, lz1;
  logic [7:0] z0, z1;
  logic [2:0] sz0, sz1;

  // Depth 4 and a non-power-of-two depth 3, driven by the same stimulus.
  mgc_out_fifo_wait_grn #(
    .rscid  (1),
    .width  (8),
    .fifo_sz(4),
    .ph_log2(2)
  ) u_dut4 (
    .clk (clk),
    .srst(srst),
    .en  (en),
    .ld  (ld),
    .vd  (vd0),
    .d   (d),
    .lz  (lz0),
    .vz  (vz),
    .z   (z0),
    .sz  (sz0)
  );

  mgc_out_fifo_wait_grn #(
    .rscid  (2),
    .width  (8),
    .fifo_sz(3),
    .ph_log2(2)
  ) u_dut3 (
    .clk (clk),
    .srst(srst),
    .en  (en),
    .ld  (ld),
    .vd  (vd1),
    .d   (d),
    .lz  (lz1),
    .vz  (vz),
    .z   (z1),
    .sz  (sz1)
  );

  always #5 clk = ~clk;

  int n_vec;
  int n_cmp;
  int n_bad;

  // Model: ordered list of held words per FIFO, head at index 0.
  logic [7:0] mlist [2][4];
  int         mcnt  [2];
  bit         mvalid;

  function automatic int depth_of(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic       exp_lz;
    logic [7:0] exp_z;
    logic       a_vd, a_lz;
    logic [7:0] a_z;
    logic [2:0] a_sz;
    for (int i = 0; i < 2; i++) begin
      exp_lz = (mcnt[i] > 0);
      exp_z  = exp_lz ? mlist[i][0] : 8'h00;
`ifdef MGC_OUT_FIFO_BYPASS_EN
      if (mcnt[i] == 0 && ld) begin
        exp_lz = 1'b1;
        exp_z  = d;
      end
`endif
      if (i == 0) begin
        a_vd = vd0; a_lz = lz0; a_z = z0; a_sz = sz0;
      end else begin
        a_vd = vd1; a_lz = lz1; a_z = z1; a_sz = sz1;
      end
      chk($sformatf("model d%0d.vd", depth_of(i)), 32'(a_vd), 32'(mcnt[i] < depth_of(i)));
      chk($sformatf("model d%0d.lz", depth_of(i)), 32'(a_lz), 32'(exp_lz));
      chk($sformatf("model d%0d.z", depth_of(i)), 32'(a_z), 32'(exp_z));
      chk($sformatf("model d%0d.sz", depth_of(i)), 32'(a_sz), 32'(mcnt[i]));
    end
  endtask

  task automatic model_update();
    bit rd;
    bit wr;
    for (int i = 0; i < 2; i++) begin
      if (srst) begin
        mcnt[i] = 0;
      end else if (en) begin
        rd = vz && (mcnt[i] > 0);
        wr = ld && (mcnt[i] < depth_of(i));
`ifdef MGC_OUT_FIFO_BYPASS_EN
        if (mcnt[i] == 0 && ld && vz) begin
          rd = 1'b0;
          wr = 1'b0;
        end
`endif
        if (rd) begin
          for (int j = 0; j < 3; j++) mlist[i][j] = mlist[i][j+1];
          mcnt[i]--;
        end
        if (wr) begin
          mlist[i][mcnt[i]] = d;
          mcnt[i]++;
        end
      end
    end
    if (srst) mvalid = 1'b1;
  endtask

  // One clock: apply inputs, compare against the model mid-cycle, advance the
  // model on the edge, return just after the edge.
  task automatic cyc(input logic r, input logic e, input logic l, input logic v,
                     input logic [7:0] dd);
    srst = r; en = e; ld = l; vz = v; d = dd;
    @(negedge clk);
    if (mvalid) model_check();
    @(posedge clk);
    model_update();
    n_vec++;
    #1;
  endtask

  initial begin
    logic       r, e, l, v;
    logic [7:0] dd;
    int         ph;
    clk = 1'b0; srst = 1'b1; en = 1'b0; ld = 1'b0; vz = 1'b0; d = 8'h00;
    n_vec = 0; n_cmp = 0; n_bad = 0; mvalid = 1'b0;
    mcnt[0] = 0; mcnt[1] = 0;

    // Reset state, fill to full, dropped write, drain in order.
    cyc(1, 1, 0, 0, 8'h00);
    chk("reset sz", 32'(sz0), 0);
    chk("reset vd", 32'(vd0), 1);
    chk("reset lz", 32'(lz0), 0);
    chk("reset z", 32'(z0), 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 1, 0, 8'((k + 1) * 17));
      chk("fill sz", 32'(sz0), 32'(k + 1));
    end
    chk("full vd", 32'(vd0), 0);
    cyc(0, 1, 1, 0, 8'h55);
    chk("drop sz", 32'(sz0), 4);
    for (int k = 0; k < 4; k++) begin
      chk("drain lz", 32'(lz0), 1);
      chk("drain z", 32'(z0), 32'((k + 1) * 17));
      cyc(0, 1, 0, 1, 8'h00);
    end
    chk("empty lz", 32'(lz0), 0);
    chk("empty z", 32'(z0), 0);
    chk("empty sz", 32'(sz0), 0);

    // Full with simultaneous read and write: write refused, then accepted.
    cyc(1, 1, 0, 0, 8'h00);
    for (int k = 0; k < 4; k++) cyc(0, 1, 1, 0, 8'((k + 1) * 17));
    cyc(0, 1, 1, 1, 8'h66);
    chk("fullrw sz", 32'(sz0), 3);
    chk("fullrw z", 32'(z0), 32'h22);
    chk("fullrw vd", 32'(vd0), 1);
    cyc(0, 1, 1, 1, 8'h77);
    chk("rw sz", 32'(sz0), 3);
    chk("rw z", 32'(z0), 32'h33);
    repeat (4) cyc(0, 1, 0, 1, 8'h00);

    // Depth-3 streaming through pointer wrap.
    cyc(1, 1, 0, 0, 8'h00);
    cyc(0, 1, 1, 0, 8'd0);
    for (int k = 1; k <= 10; k++) begin
      chk("stream z", 32'(z1), 32'(k - 1));
      chk("stream sz", 32'(sz1), 1);
      cyc(0, 1, 1, 1, 8'(k));
    end
    chk("stream end z", 32'(z1), 10);

    // Clock enable low freezes everything.
    cyc(1, 1, 0, 0, 8'h00);
    cyc(0, 1, 1, 0, 8'hA1);
    cyc(0, 1, 1, 0, 8'hA2);
    repeat (3) begin
      cyc(0, 0, 1, 1, 8'hEE);
      chk("en0 sz", 32'(sz0), 2);
      chk("en0 z", 32'(z0), 32'hA1);
    end
    cyc(0, 1, 0, 1, 8'h00);
    chk("resume z", 32'(z0), 32'hA2);
    chk("resume sz", 32'(sz0), 1);

    // Reset while holding data and writing.
    cyc(1, 1, 0, 0, 8'h00);
    cyc(0, 1, 1, 0, 8'hB1);
    cyc(0, 1, 1, 0, 8'hB2);
    cyc(0, 1, 1, 0, 8'hB3);
    cyc(1, 1, 1, 0, 8'hCC);
    ld = 1'b0;
    #1;
    chk("srst sz", 32'(sz0), 0);
    chk("srst lz", 32'(lz0), 0);
    chk("srst vd", 32'(vd0), 1);
    chk("srst z", 32'(z0), 0);
    repeat (3) begin
      cyc(0, 1, 0, 1, 8'h00);
      chk("srst stays empty", 32'(lz0), 0);
    end

`ifdef MGC_OUT_FIFO_BYPASS_EN
    cyc(1, 1, 0, 0, 8'h00);
    srst = 1'b0; en = 1'b1; ld = 1'b1; vz = 1'b1; d = 8'hA5;
    #1;
    chk("byp lz", 32'(lz0), 1);
    chk("byp z", 32'(z0), 32'hA5);
    cyc(0, 1, 1, 1, 8'hA5);
    chk("byp sz", 32'(sz0), 0);
    cyc(0, 1, 1, 0, 8'hA5);
    chk("byp store sz", 32'(sz0), 1);
    chk("byp store z", 32'(z0), 32'hA5);
`endif

    // Randomised traffic with phases biased towards full, mixed and empty.
    for (int n = 0; n < 3000; n++) begin
      ph = (n / 200) % 3;
      r  = ($urandom_range(0, 99) == 0);
      e  = ($urandom_range(0, 9) < 8);
      l  = ($urandom_range(0, 9) < ((ph == 0) ? 8 : (ph == 1) ? 5 : 2));
      v  = ($urandom_range(0, 9) < ((ph == 0) ? 2 : (ph == 1) ? 5 : 8));
      dd = 8'($urandom);
      cyc(r, e, l, v, dd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
